// File: rtl/seg_scan_display.sv
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// Shows a load-latched hex value, or "Err or", with per-digit decimal points,
// optional leading-zero blanking and optional whole-display blinking.
// All enables and segments are active-low.
module seg_scan_display #(
  parameter int DIGITS      = 8,
  parameter int SCAN_CYCLES = 10000,
  parameter int BLINK_SCANS = 50
) (
  input  logic                  clk_g,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  error,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  output logic [DIGITS-1:0]     led_en,
  output logic [6:0]            led_seg,
  output logic                  led_dp
);

  localparam int CNT_W = $clog2(SCAN_CYCLES);
  localparam int PTR_W = $clog2(DIGITS);
  localparam int FRM_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_SCANS - 1);

  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   dp_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                phase_off_q, phase_off_d;
  logic [DIGITS-1:0]   en_q, en_d;
  logic [6:0]          seg_q, seg_d;
  logic                ldp_q, ldp_d;
  logic                boundary;
  logic [4*DIGITS-1:0] upper;
  logic [3:0]          nib;
  logic                lz_blank;

  // Hex nibble to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0011000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b0100111;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  // "Err or" occupies digits 4..0; anything above is blank.
  function automatic logic [6:0] err_seg(input logic [PTR_W-1:0] d);
    if (d == PTR_W'(4))      err_seg = 7'b0000110;
    else if (d == PTR_W'(3)) err_seg = 7'b0101111;
    else if (d == PTR_W'(2)) err_seg = 7'b0101111;
    else if (d == PTR_W'(1)) err_seg = 7'b0100011;
    else if (d == PTR_W'(0)) err_seg = 7'b0101111;
    else                     err_seg = 7'b1111111;
  endfunction

  // Next state of the slot counter, digit pointer and blink frame/phase.
  always_comb begin
    boundary    = (cnt_q == CNT_LAST);
    cnt_d       = boundary ? '0 : cnt_q + CNT_W'(1);
    ptr_d       = ptr_q;
    frm_d       = frm_q;
    phase_off_d = phase_off_q;
    if (boundary) ptr_d = (ptr_q == '0) ? PTR_TOP : ptr_q - PTR_W'(1);
    if (!blink_en) begin
      frm_d       = '0;
      phase_off_d = 1'b0;
    end else if (boundary && ptr_q == '0) begin
      // Frame ends on the digit-0 slot; phase flips after the last frame.
      if (frm_q == FRM_LAST) begin
        frm_d       = '0;
        phase_off_d = ~phase_off_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  // Decode the digit named by ptr_q; applied to the outputs at a boundary.
  always_comb begin
    upper    = value_q >> {ptr_q, 2'b00};
    nib      = value_q[{ptr_q, 2'b00} +: 4];
    lz_blank = blank_lz && (ptr_q != '0) && (upper == '0);
    en_d     = '1;
    seg_d    = 7'b1111111;
    ldp_d    = 1'b1;
    if (error) begin
      seg_d = err_seg(ptr_q);
    end else if (!lz_blank) begin
      seg_d = hex_seg(nib);
      ldp_d = ~dp_q[ptr_q];
    end
    // Phase is treated as "on" whenever blinking is disabled at this edge.
    if (!(blink_en && phase_off_q)) en_d[ptr_q] = 1'b0;
  end

  // Value and decimal-point latch, captured on load.
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      dp_q    <= '0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp_in;
    end
  end

  // Scan and blink state registers.
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ptr_q       <= PTR_TOP;
      frm_q       <= '0;
      phase_off_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      frm_q       <= frm_d;
      phase_off_q <= phase_off_d;
    end
  end

  // Output registers, updated only at slot boundaries.
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      en_q  <= '1;
      seg_q <= 7'b1111111;
      ldp_q <= 1'b1;
    end else if (boundary) begin
      en_q  <= en_d;
      seg_q <= seg_d;
      ldp_q <= ldp_d;
    end
  end

  assign led_en  = en_q;
  assign led_seg = seg_q;
  assign led_dp  = ldp_q;

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits with active-low enables and segments. It is the general display back end for calculator and counter designs. It shows a latched hex value, or an "Err or" message, on any number of digits. Beyond a fixed 8-digit hex scanner it adds a load-strobed value latch, per-digit decimal points, leading-zero blanking and whole-display blinking.

## Interface
- DIGITS, 8, number of digits scanned; legal range 5..16.
- SCAN_CYCLES, 10000, clock cycles each digit stays lit; must be at least 2.
- BLINK_SCANS, 50, number of complete frames per blink half-period; must be at least 1.
- clk_g  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  when high, capture value and dp_in at the next edge.
- value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i], digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point request per digit, active-high.
- error  in  1  show the error message instead of the value (level).
- blank_lz  in  1  enable leading-zero blanking (level).
- blink_en  in  1  enable blinking (level).
- led_en  out  DIGITS  digit enables, active-low, one-hot-low.
- led_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- led_dp  out  1  decimal point, active-low.

## Operation
- Latch: on load, value_q ← value and dp_q ← dp_in. Both latches reset to 0.
- Scan counter cnt runs 0..SCAN_CYCLES-1 and wraps. Its width is $clog2(SCAN_CYCLES). A boundary is the cycle in which cnt == SCAN_CYCLES-1.
- Pointer ptr names the next digit to drive. It resets to DIGITS-1. At every boundary edge ptr decrements, and wraps from 0 back to DIGITS-1.
- All outputs are registered and update only at boundary edges. On each boundary the block decodes digit ptr from the current error, blank_lz, blink_en, value_q and dp_q.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=0100111, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Error mode:
  - digits DIGITS-1..5 are blank;
  - digit 4=E (0000110), 3=r (0101111), 2=r, 1=o (0100011), 0=r;
  - led_dp is 1 (off);
  - blanking does not apply.
- Leading-zero blanking, when blank_lz=1 and error=0:
  - a digit above the highest nonzero nibble of value_q shows blank with dp off;
  - digit 0 is never blanked, so value_q=0 shows a single "0".
- Decimal point: led_dp = ~dp_q[ptr] for digits that are not blanked.
- Blink:
  - A frame ends at the boundary that drives digit 0. The frame counter counts 0..BLINK_SCANS-1.
  - At the boundary that wraps the frame counter, phase toggles.
  - While phase=off, led_en is all ones; led_seg and led_dp still update.
  - blink_en=0 clears the frame counter and forces phase=on at the next edge.
- Digit enable: led_en = all ones except bit ptr, which is 0, subject to the blink rule.

## Timing
- Reset (async, immediate):
  - led_en = all ones, led_seg = 1111111, led_dp = 1;
  - cnt=0, ptr=DIGITS-1;
  - value_q=0, dp_q=0;
  - frame counter 0, phase=on.
- After reset release, the first boundary edge is the SCAN_CYCLES-th rising edge. It lights digit DIGITS-1. Each digit is lit for exactly SCAN_CYCLES cycles, and a full frame is DIGITS*SCAN_CYCLES cycles.
- load latency: value_q updates one edge after load. It becomes visible on the next digit driven after that edge, with no partial-slot glitch.
- A load coinciding with a boundary: the decode uses the old value_q, and the new value applies from the following boundary.
- error, blank_lz and blink_en are sampled only at boundary edges. A change takes effect at the next boundary, at most SCAN_CYCLES cycles later.
- Blink half-period is BLINK_SCANS*DIGITS*SCAN_CYCLES cycles. Phase transitions align to the boundary that drives digit 0.
- Reset asserted mid-slot or mid-blink: outputs blank immediately and the scan restarts from digit DIGITS-1.

## Test plan
- Reset and scan (DIGITS=8, SCAN_CYCLES=4): release rst with value_q=0 → led_en=0x7F first at edge 4, then 0xBF at edge 8, …, 0xFE at edge 32, then back to 0x7F. led_seg=1000000 on every digit.
- Hex decode: load value=0x89ABCDEF → digits 7..0 show 8,9,A,b,C,d,E,F with the encodings above; led_dp=1 throughout.
- Error: error=1 → digits 7..5 show 1111111; digits 4..0 show 0000110, 0101111, 0101111, 0100011, 0101111; dp off. Deasserting error restores the value from the next boundary.
- Leading-zero blanking and dp: blank_lz=1, value=0x00000305, dp_in=0x04 → digits 7..3 blank; digit 2=0110000 with led_dp=0; digit 1=1000000; digit 0=0010010. Then value=0 → only digit 0 lit, showing 1000000.
- Blink (BLINK_SCANS=2): blink_en=1 → led_en lit for 2 frames, all ones for 2 frames, repeating. Clearing blink_en mid-off phase → digits lit again from the next boundary.
- Mid-operation reset and load/boundary collision:
  - load asserted on the boundary cycle → the old value is shown for that slot and the new value from the next slot;
  - rst pulsed mid-slot → outputs go blank the same cycle, and digit 7 lights SCAN_CYCLES edges after release.
